// File: rtl/data_packer_pkg.sv
// rtl/data_packer_pkg.sv - shared widths, lane-count type and word-width helper for the data packer
package data_packer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LANES_DEF  = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int LANE_CNT_W = 3;

    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

    function automatic int word_width(input int data_w, input int lanes);
        return data_w * lanes;
    endfunction

endpackage

// File: rtl/data_packer_sync_word_fifo.sv
// rtl/data_packer_sync_word_fifo.sv - first-word-fall-through word FIFO with wrap-bit pointers
// Ports: clk, reset (async, active-high); push/din write side; pop/dout read side
// (dout is the head word whenever empty=0); full, empty status.
module sync_word_fifo
    import data_packer_pkg::*;
#(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic wr_en, rd_en;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        // Same slot address but opposite wrap bits means the writer lapped the reader.
        full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        rd_en = pop && !empty;
        // A pop on the same edge frees the slot the write lands in, so a full
        // FIFO still accepts the push.
        wr_en = push && (!full || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        dout = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is never observed while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/data_packer.sv
// rtl/data_packer.sv - packs LANES consecutive samples into one word and queues it in a word FIFO
// Ports: clk, reset (async, active-high); in_valid/in_data sample stream (no backpressure);
// flush pushes the partial word; out_valid/out_ready/out_data/out_count head-word handshake;
// full FIFO status; drop_count saturating count of words lost to overflow.
module data_packer
    import data_packer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W*LANES-1:0] out_data,
    output lane_cnt_t               out_count,
    output logic                    full,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int        WORD_W    = word_width(DATA_W, LANES);
    localparam int        FIFO_W    = WORD_W + LANE_CNT_W;
    localparam lane_cnt_t LAST_LANE = lane_cnt_t'(LANES - 1);
    localparam lane_cnt_t CNT_ONE   = lane_cnt_t'(1);

    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] merged;
    lane_cnt_t         idx_q, idx_d;
    lane_cnt_t         fill_cnt;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    logic              push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_din, fifo_dout;

    always_comb begin
        // The incoming byte is merged before any push decision so that a flush
        // in the same cycle carries it.
        merged = asm_q;
        if (in_valid) begin
            merged[int'(idx_q)*DATA_W +: DATA_W] = in_data;
        end
        fill_cnt = in_valid ? idx_q + CNT_ONE : idx_q;

        // A completed word and a flush on the same byte collapse into one push.
        push = (in_valid && (idx_q == LAST_LANE)) || (flush && (fill_cnt != '0));

        asm_d = asm_q;
        idx_d = idx_q;
        if (push) begin
            // Clearing here is what keeps unwritten upper lanes zero next word.
            asm_d = '0;
            idx_d = '0;
        end else if (in_valid) begin
            asm_d = merged;
            idx_d = fill_cnt;
        end

        fifo_din = {fill_cnt, merged};
        pop      = !fifo_empty && out_ready;
        drop     = push && fifo_full && !pop;

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q        <= '0;
            idx_q        <= '0;
            drop_count_q <= '0;
        end else begin
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            drop_count_q <= drop_count_d;
        end
    end

    sync_word_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stale RAM contents are masked so an empty FIFO presents zeros.
    always_comb begin
        out_valid  = !fifo_empty;
        out_data   = fifo_empty ? '0 : fifo_dout[WORD_W-1:0];
        out_count  = fifo_empty ? '0 : fifo_dout[FIFO_W-1 -: LANE_CNT_W];
        full       = fifo_full;
        drop_count = drop_count_q;
    end

endmodule

// File: tb/tb_data_packer.sv
// tb/tb_data_packer.sv - self-checking bench for data_packer
module tb_data_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        full;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cnt;
    } word_t;

    word_t mq[$];
    int    part[$];
    int    mdrop;

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        f;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl[$];

    data_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .full       (full),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_bytes(input int b0, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = w | (32'((b0 + i) & 8'hFF) << (8 * i));
        return w;
    endfunction

    // Reference: whole-word queue plus a list of pending bytes.
    task automatic model_edge(input logic iv, input logic [7:0] d, input logic f, input logic rdy);
        word_t w;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (iv) part.push_back(int'(d));
        if (part.size() == 4 || (f && part.size() > 0)) begin
            w.data = '0;
            foreach (part[i]) w.data = w.data | (32'(part[i]) << (8 * i));
            w.cnt = part.size();
            if (mq.size() < 4) mq.push_back(w);
            else if (mdrop < 65535) mdrop++;
            part.delete();
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".data"}, out_data, (mq.size() > 0) ? mq[0].data : 32'h0);
        chk({tag, ".count"}, 32'(out_count), (mq.size() > 0) ? 32'(mq[0].cnt) : 32'h0);
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == 4));
        chk({tag, ".drop"}, 32'(drop_count), 32'(mdrop));
    endtask

    // Called at a negedge: drive, run one rising edge, sample at the next negedge.
    task automatic step(input logic iv, input logic [7:0] d, input logic f, input logic rdy, input string tag);
        in_valid  = iv;
        in_data   = d;
        flush     = f;
        out_ready = rdy;
        model_edge(iv, d, f, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        part.delete();
        mdrop = 0;
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.data", out_data, 32'h0);
        chk("rst.count", 32'(out_count), 32'h0);
        chk("rst.full", 32'(full), 32'h0);
        chk("rst.drop", 32'(drop_count), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        mdrop     = 0;

        tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 32'h03020100, 3'd4});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 3'd2});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 32'h00332211, 3'd3});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});
        tbl.push_back('{1'b1, 8'h43, 1'b1, 1'b0, 1'b1, 32'h43424140, 3'd4});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h43424140, 3'd4});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0});

        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].f, tbl[i].rdy, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.v", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.d", i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d.c", i), 32'(out_count), 32'(tbl[i].ec));
        end

        // Overflow: six words into a four-deep FIFO with the consumer stalled.
        do_reset();
        for (int k = 0; k < 24; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, "ovf");
        chk("ovf.full", 32'(full), 32'h1);
        chk("ovf.drop", 32'(drop_count), 32'd2);
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("ovf.drain%0d", w), out_data, pack_bytes(8'h20 + 4 * w, 4));
            step(1'b0, 8'h00, 1'b0, 1'b1, "ovf.drain");
        end
        chk("ovf.empty", 32'(out_valid), 32'h0);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int k = 0; k < 19; k++) step(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, "fpp");
        step(1'b1, 8'h63, 1'b0, 1'b1, "fpp.swap");
        chk("fpp.drop", 32'(drop_count), 32'h0);
        chk("fpp.full", 32'(full), 32'h1);
        for (int w = 1; w < 5; w++) begin
            chk($sformatf("fpp.order%0d", w), out_data, pack_bytes(8'h50 + 4 * w, 4));
            step(1'b0, 8'h00, 1'b0, 1'b1, "fpp.drain");
        end
        chk("fpp.empty", 32'(out_valid), 32'h0);

        // Reset in the middle of a word.
        do_reset();
        step(1'b1, 8'hE1, 1'b0, 1'b1, "rmw");
        step(1'b1, 8'hE2, 1'b0, 1'b1, "rmw");
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b1, "rmw.new");
        chk("rmw.data", out_data, 32'h13121110);
        chk("rmw.count", 32'(out_count), 32'd4);
        chk("rmw.drop", 32'(drop_count), 32'h0);

        // Randomised traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                 1'($urandom_range(0, 2) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
